// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Fetch entries pair an instruction word with the address it was fetched from.
package ifu_pkg;

    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [XLEN-1:0] instr_t;

    localparam instr_t INSTR_BUBBLE = 32'd0;
    localparam addr_t  WORD_MASK    = ~addr_t'(3);

    typedef struct packed {
        addr_t  addr;
        instr_t instr;
    } fetch_entry_t;

    function automatic addr_t align_word(input addr_t a);
        return a & WORD_MASK;
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO of {addr, instr} entries with synchronous clear.
// Head entry is read combinationally from registered storage.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = $bits(fetch_entry_t)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_q, wr_d;
    logic [PTR_W:0]   rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    always_comb begin
        count_o = wr_q - rd_q;
        empty_o = (wr_q == rd_q);
        full_o  = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                  (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (clr_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + (PTR_W+1)'(1);
            if (do_pop)  rd_d = rd_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr_i) begin
            mem_q[wr_q[PTR_W-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_q[PTR_W-1:0]];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues word requests, buffers responses
// and presents one instruction/address pair per cycle to the decoder.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        rd_conflict_i,
    input  logic        flush_from_exe_i,
    input  logic [31:0] flush_addr_exe_i,
    input  logic        flush_from_dec_i,
    input  logic [31:0] flush_addr_dec_i,
    output logic [31:0] instr_ifu_2_dec_o,
    output logic [31:0] instr_addr_ifu_2_dec_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int AQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int SUM_W = CNT_W + 1;

    addr_t            pc_q, pc_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OUT_W-1:0] discard_q, discard_d;
    logic [AQ_W-1:0]  aq_wr_q, aq_wr_d;
    logic [AQ_W-1:0]  aq_rd_q, aq_rd_d;
    addr_t [MAX_OUTSTANDING-1:0] aq_slots;

    logic             flush_any;
    addr_t            flush_target;
    logic [SUM_W-1:0] occupancy;
    logic             issue;
    logic             handshake;
    logic             resp_keep;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    function automatic logic [AQ_W-1:0] aq_next(input logic [AQ_W-1:0] p);
        if (p == AQ_W'(MAX_OUTSTANDING - 1)) return '0;
        return p + AQ_W'(1);
    endfunction

    // Issue is limited so every in-flight response is guaranteed a FIFO slot.
    always_comb begin
        flush_any    = flush_from_exe_i | flush_from_dec_i;
        flush_target = align_word(flush_from_exe_i ? flush_addr_exe_i : flush_addr_dec_i);
        occupancy    = SUM_W'(fifo_count) + SUM_W'(out_q);
        issue        = !rst && !flush_any &&
                       (occupancy < SUM_W'(FIFO_DEPTH)) &&
                       (out_q < OUT_W'(MAX_OUTSTANDING));
        handshake    = issue && imem_ready_i;
        fifo_pop     = !fifo_empty && !rd_conflict_i && !flush_any;
        resp_keep    = imem_rvalid_i && (discard_q == '0) && !flush_any;
        fifo_push    = resp_keep && (!fifo_full || fifo_pop);
        push_entry   = '{addr: aq_slots[aq_rd_q], instr: imem_rdata_i};
    end

    always_comb begin
        pc_d      = pc_q;
        out_d     = out_q + OUT_W'(handshake) - OUT_W'(imem_rvalid_i);
        discard_d = discard_q;
        aq_wr_d   = handshake ? aq_next(aq_wr_q) : aq_wr_q;
        aq_rd_d   = imem_rvalid_i ? aq_next(aq_rd_q) : aq_rd_q;
        if (flush_any) begin
            pc_d      = flush_target;
            // Everything still in flight belongs to the abandoned stream.
            discard_d = out_d;
        end else begin
            if (handshake) pc_d = pc_q + addr_t'(PC_STEP);
            if (imem_rvalid_i && (discard_q != '0)) discard_d = discard_q - OUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            out_q     <= '0;
            discard_q <= '0;
            aq_wr_q   <= '0;
            aq_rd_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            out_q     <= out_d;
            discard_q <= discard_d;
            aq_wr_q   <= aq_wr_d;
            aq_rd_q   <= aq_rd_d;
        end
    end

    // In-order address queue: one slot per possible in-flight request.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_aq
            addr_t slot_q;
            always_ff @(posedge clk) begin
                if (handshake && (aq_wr_q == AQ_W'(gi))) begin
                    slot_q <= pc_q;
                end
            end
            assign aq_slots[gi] = slot_q;
        end
    endgenerate

    ifu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush_any),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign imem_req_o             = issue;
    assign imem_addr_o            = pc_q;
    assign instr_ifu_2_dec_o      = fifo_empty ? INSTR_BUBBLE : head_entry.instr;
    assign instr_addr_ifu_2_dec_o = fifo_empty ? INSTR_BUBBLE : head_entry.addr;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with an in-order memory model and an
// address scoreboard checked whenever the decoder consumes an instruction.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] XORPAT = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'd0;
    logic        rd_conflict_i = 1'b0;
    logic        flush_from_exe_i = 1'b0;
    logic [31:0] flush_addr_exe_i = 32'd0;
    logic        flush_from_dec_i = 1'b0;
    logic [31:0] flush_addr_dec_i = 32'd0;
    logic [31:0] instr_o;
    logic [31:0] addr_o;

    ifu_fetch #(
        .RESET_PC        (RST_PC),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .imem_req_o             (imem_req_o),
        .imem_addr_o            (imem_addr_o),
        .imem_ready_i           (imem_ready_i),
        .imem_rvalid_i          (imem_rvalid_i),
        .imem_rdata_i           (imem_rdata_i),
        .rd_conflict_i          (rd_conflict_i),
        .flush_from_exe_i       (flush_from_exe_i),
        .flush_addr_exe_i       (flush_addr_exe_i),
        .flush_from_dec_i       (flush_from_dec_i),
        .flush_addr_dec_i       (flush_addr_dec_i),
        .instr_ifu_2_dec_o      (instr_o),
        .instr_addr_ifu_2_dec_o (addr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int ready_mode = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Memory: responds in order, one word per cycle, lat cycles after acceptance.
    always begin
        @(posedge clk);
        #1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_q[0].addr ^ XORPAT;
            void'(mem_q.pop_front());
        end
        imem_ready_i = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
    end

    // Request capture and decoder-side scoreboard.
    always @(negedge clk) begin
        if (!rst && imem_req_o && imem_ready_i) begin
            mem_q.push_back('{addr: imem_addr_o, due: cyc + lat});
            chk("max_outstanding", 32'(mem_q.size() <= 2), 32'd1);
        end
        if (!rst && !(flush_from_exe_i | flush_from_dec_i) && !rd_conflict_i && instr_o !== 32'd0) begin
            $display("consume addr=%h instr=%h", addr_o, instr_o);
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", addr_o, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("sb_addr", addr_o, e);
                chk("sb_instr", instr_o, e ^ XORPAT);
            end
        end
    end

    // Caller is at the start of a cycle; rst is held for exactly one cycle.
    task automatic apply_reset();
        rd_conflict_i    = 1'b0;
        flush_from_exe_i = 1'b0;
        flush_from_dec_i = 1'b0;
        rst = 1'b1;
        mem_q.delete();
        exp_q.delete();
        @(negedge clk);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        step();
        rst = 1'b0;
        push_exp(RST_PC, 64);
        @(negedge clk);
        chk("rel_req", 32'(imem_req_o), 32'd1);
        chk("rel_req_addr", imem_addr_o, RST_PC);
        chk("rel_instr_zero", instr_o, 32'd0);
        chk("rel_addr_zero", addr_o, 32'd0);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk("pre_first_zero", instr_o, 32'd0);
        end
        @(negedge clk);
        chk("first_addr", addr_o, RST_PC);
        chk("first_instr", instr_o, RST_PC ^ XORPAT);
    endtask

    task automatic wait_addr(input string tag, input logic [31:0] a);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (addr_o !== a && n < 50);
        chk(tag, addr_o, a);
    endtask

    task automatic wait_valid(input string tag, input logic [31:0] a);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (instr_o === 32'd0 && n < 50);
        chk(tag, addr_o, a);
    endtask

    task automatic do_flush(input logic exe, input logic [31:0] ea,
                            input logic dec, input logic [31:0] da,
                            input logic [31:0] expect_pc, input string tag);
        step();
        flush_from_exe_i = exe;
        flush_addr_exe_i = ea;
        flush_from_dec_i = dec;
        flush_addr_dec_i = da;
        push_exp(expect_pc, 64);
        @(negedge clk);
        chk({tag, "_no_issue"}, 32'(imem_req_o), 32'd0);
        step();
        flush_from_exe_i = 1'b0;
        flush_from_dec_i = 1'b0;
        @(negedge clk);
        chk({tag, "_bubble"}, instr_o, 32'd0);
        wait_valid({tag, "_first"}, expect_pc);
    endtask

    initial begin
        // Reset, latency and stream start with a 1-cycle memory.
        lat = 1;
        ready_mode = 0;
        step();
        apply_reset();

        // Decoder stall holds 0x108 while the FIFO fills.
        wait_addr("head_104", 32'h0000_0104);
        step();
        rd_conflict_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_addr", addr_o, 32'h0000_0108);
            chk("hold_instr", instr_o, 32'h0000_0108 ^ XORPAT);
            if (k == 2) chk("req_drop_full", 32'(imem_req_o), 32'd0);
            step();
        end
        rd_conflict_i = 1'b0;
        @(negedge clk);
        chk("req_still_full", 32'(imem_req_o), 32'd0);
        wait_addr("after_hold", 32'h0000_010C);
        repeat (4) @(negedge clk);

        // Exe flush with two requests in flight on a 3-cycle memory.
        step();
        lat = 3;
        apply_reset();
        begin
            int n = 0;
            do begin
                @(negedge clk);
                #2;
                n++;
            end while (mem_q.size() < 2 && n < 50);
            chk("two_in_flight", 32'(mem_q.size()), 32'd2);
        end
        do_flush(1'b1, 32'h0000_0200, 1'b0, 32'h0, 32'h0000_0200, "flush_exe");
        repeat (8) @(negedge clk);

        // Simultaneous redirects: exe wins and its target is word-aligned.
        do_flush(1'b1, 32'h0000_0302, 1'b1, 32'h0000_0400, 32'h0000_0300, "flush_both");
        repeat (6) @(negedge clk);

        // Dec-only redirect, then toggling ready with 3-cycle latency.
        do_flush(1'b0, 32'h0, 1'b1, 32'h0000_0503, 32'h0000_0500, "flush_dec");
        ready_mode = 1;
        repeat (40) @(negedge clk);
        chk("toggle_progress", 32'(exp_q.size() < 58), 32'd1);

        // Fill the FIFO under stall, then reset mid-stream.
        step();
        ready_mode = 0;
        lat = 1;
        rd_conflict_i = 1'b1;
        repeat (10) step();
        @(negedge clk);
        chk("full_before_rst", 32'(imem_req_o), 32'd0);
        chk("full_head_valid", 32'(instr_o !== 32'd0), 32'd1);
        step();
        apply_reset();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
